// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches on credit, buffers
// returned instructions with their PCs, and flushes/restarts on redirect.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [31:0]                imem_req_addr,
  input  logic                       imem_resp_valid,
  input  logic [31:0]                imem_resp_data,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned IW = 16;

  logic          r_run;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_inflight;
  logic [IW-1:0] r_discard;
  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_pc    [DEPTH];

  logic [IW:0]   w_used;
  logic          w_accept;
  logic          w_keep;
  logic          w_deq;
  logic [IW-1:0] w_inflight_nxt;
  logic          w_unused_pc_lsb;

  // Credit counts kept responses only: discarded in-flight requests never land.
  assign w_used = {{(IW+1-CW){1'b0}}, r_count} + {1'b0, r_inflight} - {1'b0, r_discard};

  assign imem_req_valid  = r_run && !redirect && (w_used < (IW+1)'(DEPTH));
  assign imem_req_addr   = r_fetch_pc;
  assign w_accept        = imem_req_valid && imem_req_ready;
  assign w_keep          = imem_resp_valid && (r_discard == '0);
  assign w_deq           = out_valid && out_ready;
  assign w_unused_pc_lsb = &redirect_pc[1:0];

  assign out_valid = (r_count != '0);
  assign out_instr = r_instr[r_rd_ptr];
  assign out_pc    = r_pc[r_rd_ptr];
  assign count     = r_count;

  always_comb begin
    w_inflight_nxt = r_inflight;
    if (w_accept)
      w_inflight_nxt = w_inflight_nxt + IW'(1);
    if (imem_resp_valid)
      w_inflight_nxt = w_inflight_nxt - IW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_discard  <= '0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_inflight_nxt;
      if (redirect) begin
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
        r_resp_pc  <= {redirect_pc[31:2], 2'b00};
        r_discard  <= w_inflight_nxt;
      end else begin
        if (w_accept)
          r_fetch_pc <= r_fetch_pc + 32'd4;
        if (imem_resp_valid && (r_discard != '0))
          r_discard <= r_discard - IW'(1);
        if (w_keep) begin
          r_wr_ptr  <= r_wr_ptr + PW'(1);
          r_resp_pc <= r_resp_pc + 32'd4;
        end
        if (w_deq)
          r_rd_ptr <= r_rd_ptr + PW'(1);
        case ({w_keep, w_deq})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_keep && !redirect) begin
      r_instr[r_wr_ptr] <= imem_resp_data;
      r_pc[r_wr_ptr]    <= r_resp_pc;
    end
  end

  a_resp_needs_inflight: assert property (
    @(posedge clk) disable iff (!rst) !(imem_resp_valid && (r_inflight == '0)));

endmodule
